// File: rtl/rot_cordic_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rot_cordic_iter
// Brief    : Iterative rotation-mode CORDIC with quadrant pre-rotation and a
//            single shared shift-add stage behind a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module rot_cordic_iter #(
    parameter int WIDTH = 16,
    parameter int ITER  = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] x_out,
    output logic [WIDTH+1:0] y_out,
    output logic [WIDTH-1:0] z_res,
    output logic             x_msb,
    output logic             y_msb
);

    localparam int c_dw    = WIDTH + 2;
    localparam int c_cnt_w = $clog2(ITER);
    localparam int c_shift = 32 - WIDTH;

    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(ITER - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_rot  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // round(atan(2^-i)/pi * 2^31)
    function automatic logic [31:0] atan_raw(input int i);
        case (i)
            0:       atan_raw = 32'd536870912;
            1:       atan_raw = 32'd316933406;
            2:       atan_raw = 32'd167458907;
            3:       atan_raw = 32'd85004756;
            4:       atan_raw = 32'd42667331;
            5:       atan_raw = 32'd21354465;
            6:       atan_raw = 32'd10679838;
            7:       atan_raw = 32'd5340245;
            8:       atan_raw = 32'd2670163;
            9:       atan_raw = 32'd1335087;
            10:      atan_raw = 32'd667544;
            11:      atan_raw = 32'd333772;
            12:      atan_raw = 32'd166886;
            13:      atan_raw = 32'd83443;
            14:      atan_raw = 32'd41722;
            15:      atan_raw = 32'd20861;
            16:      atan_raw = 32'd10430;
            17:      atan_raw = 32'd5215;
            18:      atan_raw = 32'd2608;
            19:      atan_raw = 32'd1304;
            20:      atan_raw = 32'd652;
            21:      atan_raw = 32'd326;
            22:      atan_raw = 32'd163;
            23:      atan_raw = 32'd81;
            default: atan_raw = 32'd0;
        endcase
    endfunction

    logic [c_dw-1:0] w_atan_tab [ITER];

    // Table reduced to the angle scale with round-half-up
    for (genvar g = 0; g < ITER; g++) begin : g_atan
        localparam logic [32:0] c_rnd =
            ({1'b0, atan_raw(g)} + (33'd1 << (c_shift - 1))) >> c_shift;
        assign w_atan_tab[g] = c_dw'(c_rnd);
    end

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [c_cnt_w-1:0]       r_cnt;
    logic signed [c_dw-1:0]   r_x;
    logic signed [c_dw-1:0]   r_y;
    logic signed [c_dw-1:0]   r_z;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else if (ce) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (in_valid)        w_state_nxt = c_st_rot;
            c_st_rot:  if (r_cnt == c_last) w_state_nxt = c_st_done;
            c_st_done: if (out_ready)       w_state_nxt = c_st_idle;
            default:                        w_state_nxt = c_st_idle;
        endcase
    end

    // |z| >= pi/2 folds into the right half-plane by a rotation of pi
    logic                   w_flip;
    logic [WIDTH-1:0]       w_z_fold;
    logic signed [c_dw-1:0] w_x_ext;
    logic signed [c_dw-1:0] w_y_ext;
    logic signed [c_dw-1:0] w_x_ld;
    logic signed [c_dw-1:0] w_y_ld;
    logic signed [c_dw-1:0] w_z_ld;

    assign w_flip   = z_in[WIDTH-1] ^ z_in[WIDTH-2];
    assign w_z_fold = {z_in[WIDTH-1] ^ w_flip, z_in[WIDTH-2:0]};
    assign w_x_ext  = {{2{x_in[WIDTH-1]}}, x_in};
    assign w_y_ext  = {{2{y_in[WIDTH-1]}}, y_in};
    assign w_x_ld   = w_flip ? -w_x_ext : w_x_ext;
    assign w_y_ld   = w_flip ? -w_y_ext : w_y_ext;
    assign w_z_ld   = {{2{w_z_fold[WIDTH-1]}}, w_z_fold};

    logic                   w_d_neg;
    logic signed [c_dw-1:0] w_xs;
    logic signed [c_dw-1:0] w_ys;
    logic signed [c_dw-1:0] w_atan;
    logic signed [c_dw-1:0] w_x_nxt;
    logic signed [c_dw-1:0] w_y_nxt;
    logic signed [c_dw-1:0] w_z_nxt;

    assign w_d_neg = r_z[c_dw-1];
    assign w_xs    = r_x >>> r_cnt;
    assign w_ys    = r_y >>> r_cnt;
    assign w_atan  = w_atan_tab[r_cnt];
    assign w_x_nxt = w_d_neg ? (r_x + w_ys)   : (r_x - w_ys);
    assign w_y_nxt = w_d_neg ? (r_y - w_xs)   : (r_y + w_xs);
    assign w_z_nxt = w_d_neg ? (r_z + w_atan) : (r_z - w_atan);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x   <= '0;
            r_y   <= '0;
            r_z   <= '0;
            r_cnt <= '0;
        end else if (ce) begin
            if (r_state == c_st_idle && in_valid) begin
                r_x   <= w_x_ld;
                r_y   <= w_y_ld;
                r_z   <= w_z_ld;
                r_cnt <= '0;
            end else if (r_state == c_st_rot) begin
                r_x   <= w_x_nxt;
                r_y   <= w_y_nxt;
                r_z   <= w_z_nxt;
                r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = (r_state == c_st_done);
    assign x_out     = r_x;
    assign y_out     = r_y;
    assign z_res     = r_z[WIDTH-1:0];
    assign x_msb     = r_x[c_dw-1];
    assign y_msb     = r_y[c_dw-1];

endmodule
`default_nettype wire

// File: tb/tb_rot_cordic_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rot_cordic_iter
// Brief    : Self-checking bench for rot_cordic_iter against a real-valued
//            angle table and an integer micro-rotation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rot_cordic_iter;

    localparam int  WIDTH = 16;
    localparam int  ITER  = 14;
    localparam int  OW    = WIDTH + 2;
    localparam real PI    = 3.14159265358979323846;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    ce = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    out_ready = 1'b0;
    logic signed [WIDTH-1:0] x_in = '0;
    logic signed [WIDTH-1:0] y_in = '0;
    logic signed [WIDTH-1:0] z_in = '0;
    logic                    in_ready;
    logic                    out_valid;
    logic signed [OW-1:0]    x_out;
    logic signed [OW-1:0]    y_out;
    logic signed [WIDTH-1:0] z_res;
    logic                    x_msb;
    logic                    y_msb;

    rot_cordic_iter #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .z_res(z_res),
        .x_msb(x_msb), .y_msb(y_msb)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_tol(input string name, input longint act, input longint exp,
                           input longint tol);
        n_vec++;
        if (act < exp - tol || act > exp + tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        longint x;
        longint y;
        longint z;
    } res_t;

    function automatic longint atan_val(input int i);
        real    r;
        longint raw;
        r   = $atan(2.0 ** (-i)) / PI * (2.0 ** 31);
        raw = longint'($floor(r + 0.5));
        return (raw + (longint'(1) << (31 - WIDTH))) >>> (32 - WIDTH);
    endfunction

    function automatic res_t model(input longint xi, input longint yi, input longint zi);
        res_t   r;
        longint x, y, z, t;
        longint q = longint'(1) << (WIDTH - 2);
        if (zi >= q || zi < -q) begin
            x = -xi;
            y = -yi;
            z = zi + 2 * q;
            if (z >= 2 * q) z = z - 4 * q;
        end else begin
            x = xi;
            y = yi;
            z = zi;
        end
        for (int i = 0; i < ITER; i++) begin
            if (z >= 0) begin
                t = x - (y >>> i);
                y = y + (x >>> i);
                z = z - atan_val(i);
            end else begin
                t = x + (y >>> i);
                y = y - (x >>> i);
                z = z + atan_val(i);
            end
            x = t;
        end
        r.x = x;
        r.y = y;
        r.z = z;
        return r;
    endfunction

    // ---------------- scoreboard / compare process ----------------
    res_t exp_q[$];
    bit   pend = 1'b0;
    bit   chk_ready = 1'b0;
    int   en_edges = 0;

    always @(negedge clk) begin
        res_t e;
        if (chk_ready) begin
            chk("in_ready_after_take", in_ready, 1);
            chk("out_valid_after_take", out_valid, 0);
            chk_ready = 1'b0;
        end
        if (pend) begin
            if (out_valid) begin
                chk("latency", en_edges, ITER);
                pend = 1'b0;
            end else if (en_edges >= ITER) begin
                chk("out_valid_late", out_valid, 1);
                pend = 1'b0;
            end
        end
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", out_valid, 0);
            end else begin
                e = exp_q[0];
                chk("x_out", x_out, e.x);
                chk("y_out", y_out, e.y);
                chk("z_res", z_res, e.z);
                chk("x_msb", x_msb, (e.x < 0) ? 1 : 0);
                chk("y_msb", y_msb, (e.y < 0) ? 1 : 0);
                chk("in_ready_in_done", in_ready, 0);
            end
        end
        if (ce && rst_n && pend) en_edges++;
        if (!rst_n) begin
            exp_q.delete();
            pend      = 1'b0;
            chk_ready = 1'b0;
        end else if (ce) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(x_in, y_in, z_in));
                pend     = 1'b1;
                en_edges = 0;
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                chk_ready = 1'b1;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic send(input int x, input int y, input int z);
        bit ok = 1'b0;
        @(posedge clk); #1;
        x_in     = WIDTH'(x);
        y_in     = WIDTH'(y);
        z_in     = WIDTH'(z);
        in_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (in_ready && ce) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_valid(output int lat);
        bit got = 1'b0;
        lat = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            lat++;
        end
        if (!got) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic take();
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_x_out"}, x_out, 0);
        chk({tag, "_y_out"}, y_out, 0);
        chk({tag, "_z_res"}, z_res, 0);
        chk({tag, "_x_msb"}, x_msb, 0);
        chk({tag, "_y_msb"}, y_msb, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   lat;
        int   n;
        int   cyc;
        bit   acc;
        res_t m;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_reset_state("reset");

        // Model pinned against hand-derived values
        m = model(10000, 0, 0);
        chk_tol("model_zero_x", m.x, 16468, 3);
        m = model(10000, 0, 24576);
        chk_tol("model_3pi4_x", m.x, -11645, 4);
        chk_tol("model_3pi4_y", m.y, 11645, 4);

        // Zero rotation
        send(10000, 0, 0);
        wait_valid(lat);
        chk("zero_latency", lat, ITER);
        chk_tol("zero_x", x_out, 16468, 3);
        chk_tol("zero_y", y_out, 0, 3);
        chk_tol("zero_z", z_res, 0, 2);
        take();

        // +pi/2
        send(10000, 0, 16384);
        wait_valid(lat);
        chk_tol("pi2_x", x_out, 0, 3);
        chk_tol("pi2_y", y_out, 16468, 3);
        chk("pi2_y_msb", y_msb, 0);
        take();

        // -pi through pre-rotation
        send(10000, 0, -32768);
        wait_valid(lat);
        chk_tol("mpi_x", x_out, -16468, 3);
        chk_tol("mpi_y", y_out, 0, 3);
        chk("mpi_x_msb", x_msb, 1);
        take();

        // 3pi/4 through pre-rotation
        send(10000, 0, 24576);
        wait_valid(lat);
        chk_tol("3pi4_x", x_out, -11645, 4);
        chk_tol("3pi4_y", y_out, 11645, 4);
        take();

        // Backpressure with an ignored input pulse
        send(1000, -2000, 5000);
        wait_valid(lat);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            in_valid = (c == 5);
            x_in     = 16'sd1234;
            z_in     = 16'sd777;
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        take();

        // ce low for 5 cycles mid-rotation
        send(-7000, 3000, -12000);
        lat = 0;
        for (int c = 0; c < 100; c++) begin
            ce = (c >= 3 && c < 8) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        chk("ce_latency", lat, ITER + 5);
        take();

        // Reset at iteration 7
        send(12345, -5432, 9000);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_state("midrst");
        send(-20000, 15000, -3000);
        wait_valid(lat);
        chk("post_rst_latency", lat, ITER);
        take();

        // Randomized traffic
        @(posedge clk); #1;
        n   = 0;
        cyc = 0;
        x_in     = WIDTH'(int'($urandom_range(65534)) - 32767);
        y_in     = WIDTH'(int'($urandom_range(65534)) - 32767);
        z_in     = WIDTH'($urandom);
        in_valid = 1'b1;
        while (n < 1000 && cyc < 60000) begin
            @(negedge clk);
            acc = in_valid && in_ready && ce;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                n++;
                x_in = WIDTH'(int'($urandom_range(65534)) - 32767);
                y_in = WIDTH'(int'($urandom_range(65534)) - 32767);
                case (n % 50)
                    0:       z_in = -16'sd32768;
                    1:       z_in = 16'sd16384;
                    2:       z_in = -16'sd16384;
                    3:       z_in = 16'sd16383;
                    4:       z_in = -16'sd16385;
                    default: z_in = WIDTH'($urandom);
                endcase
                if (n >= 1000) in_valid = 1'b0;
            end
            out_ready = ($urandom_range(3) != 0);
            ce        = ($urandom_range(15) != 0);
        end
        chk("random_samples_accepted", n, 1000);
        ce        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
